// File: rtl/sound_sequencer.sv
// Tone sequencer for the pong sound card: plays ping/pong/goal tones with
// fixed durations, silent gaps between tones, priority preemption and
// pending-request queuing (one flag per tone type).
module sound_sequencer #(
    parameter int PING_LEN = 2500000,
    parameter int PONG_LEN = 2500000,
    parameter int GOAL_LEN = 12500000,
    parameter int GAP_LEN  = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ping_req,
    input  logic       pong_req,
    input  logic       goal_req,
    output logic [1:0] sound,
    output logic       mute,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t      state, state_next;
    logic [23:0] count, count_next;
    // bit 0 = ping, bit 1 = pong, bit 2 = goal
    logic [2:0]  pend, pend_next;
    logic [1:0]  sound_next;
    logic        mute_next, busy_next;

    logic [2:0]  reqs, merged, sel_mask;
    logic [1:0]  req_top, merged_top, start_code;
    logic        start;

    // Tone code doubles as priority: goal(3) > pong(2) > ping(1) > none(0)
    function automatic logic [1:0] top_code(input logic [2:0] v);
        if (v[2])      return 2'd3;
        else if (v[1]) return 2'd2;
        else if (v[0]) return 2'd1;
        else           return 2'd0;
    endfunction

    // Counter reload value so that PLAY lasts exactly LEN cycles
    function automatic logic [23:0] load_of(input logic [1:0] code);
        case (code)
            2'd1:    return 24'(PING_LEN - 1);
            2'd2:    return 24'(PONG_LEN - 1);
            2'd3:    return 24'(GOAL_LEN - 1);
            default: return 24'd0;
        endcase
    endfunction

    // Next-state logic: selection, preemption, countdown, gap and queuing
    always_comb begin
        state_next = state;
        count_next = count;
        pend_next  = pend;
        sound_next = sound;
        mute_next  = mute;
        start      = 1'b0;
        start_code = 2'd0;
        sel_mask   = 3'b000;
        reqs       = {goal_req, pong_req, ping_req};
        merged     = pend | reqs;
        req_top    = top_code(reqs);
        merged_top = top_code(merged);

        if (!enable) begin
            state_next = IDLE;
            count_next = 24'd0;
            pend_next  = 3'b000;
            sound_next = 2'd0;
            mute_next  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_top != 2'd0) begin
                        start      = 1'b1;
                        start_code = req_top;
                    end
                end
                PLAY, GAP: begin
                    if (req_top > sound) begin
                        start      = 1'b1;
                        start_code = req_top;
                    end else begin
                        pend_next = merged;
                        if (count != 24'd0) begin
                            count_next = count - 24'd1;
                        end else if (state == PLAY && GAP_LEN != 0) begin
                            state_next = GAP;
                            count_next = 24'(GAP_LEN - 1);
                            mute_next  = 1'b1;
                        end else if (merged_top != 2'd0) begin
                            start      = 1'b1;
                            start_code = merged_top;
                        end else begin
                            state_next = IDLE;
                            pend_next  = 3'b000;
                            sound_next = 2'd0;
                            mute_next  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    pend_next  = 3'b000;
                    sound_next = 2'd0;
                    mute_next  = 1'b1;
                end
            endcase
        end

        if (start) begin
            case (start_code)
                2'd1:    sel_mask = 3'b001;
                2'd2:    sel_mask = 3'b010;
                2'd3:    sel_mask = 3'b111;
                default: sel_mask = 3'b000;
            endcase
            state_next = PLAY;
            count_next = load_of(start_code);
            sound_next = start_code;
            mute_next  = 1'b0;
            pend_next  = merged & ~sel_mask;
        end

        busy_next = (state_next != IDLE) || (pend_next != 3'b000);
    end

    // State, counter, pending flags and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= 24'd0;
            pend  <= 3'b000;
            sound <= 2'd0;
            mute  <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            pend  <= pend_next;
            sound <= sound_next;
            mute  <= mute_next;
            busy  <= busy_next;
        end
    end

    // Zero-length or oversized tones make no sense; flag them in simulation
    always_ff @(posedge clk) begin
        assert (PING_LEN > 0 && PONG_LEN > 0 && GOAL_LEN > 0 &&
                PING_LEN < 16777216 && PONG_LEN < 16777216 &&
                GOAL_LEN < 16777216 && GAP_LEN >= 0 && GAP_LEN < 16777216)
            else $error("sound_sequencer: LEN parameter out of range");
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: two instances (gap of 2 and gap of 0) share the
// same stimulus and are compared every cycle against a tone-level model.
module tb_sound_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0, enable = 1'b1;
    logic ping_req = 1'b0, pong_req = 1'b0, goal_req = 1'b0;
    logic [1:0] snd [2];
    logic       mut [2];
    logic       bsy [2];

    int checks = 0;
    int errors = 0;

    int gap_len [2] = '{2, 0};
    int m_tone  [2];
    int m_play  [2];
    int m_gap   [2];
    bit m_pend  [2][4];

    always #5 clk = ~clk;

    sound_sequencer #(.PING_LEN(4), .PONG_LEN(6), .GOAL_LEN(8), .GAP_LEN(2)) dut0 (
        .clk(clk), .rst(rst), .enable(enable),
        .ping_req(ping_req), .pong_req(pong_req), .goal_req(goal_req),
        .sound(snd[0]), .mute(mut[0]), .busy(bsy[0])
    );

    sound_sequencer #(.PING_LEN(4), .PONG_LEN(6), .GOAL_LEN(8), .GAP_LEN(0)) dut1 (
        .clk(clk), .rst(rst), .enable(enable),
        .ping_req(ping_req), .pong_req(pong_req), .goal_req(goal_req),
        .sound(snd[1]), .mute(mut[1]), .busy(bsy[1])
    );

    function automatic int tone_len(int code);
        case (code)
            1:       return 4;
            2:       return 6;
            3:       return 8;
            default: return 0;
        endcase
    endfunction

    task automatic model_clear(int k);
        m_tone[k] = 0;
        m_play[k] = 0;
        m_gap[k]  = 0;
        for (int c = 1; c <= 3; c++) m_pend[k][c] = 0;
    endtask

    task automatic model_start(int k, int code);
        m_pend[k][code] = 0;
        if (code == 3) begin
            m_pend[k][1] = 0;
            m_pend[k][2] = 0;
        end
        m_tone[k] = code;
        m_play[k] = tone_len(code);
        m_gap[k]  = 0;
    endtask

    task automatic model_decide(int k);
        int best = 0;
        for (int c = 1; c <= 3; c++) if (m_pend[k][c]) best = c;
        if (best != 0) model_start(k, best);
        else           model_clear(k);
    endtask

    // One clock of the tone-level model; r[c] is the request for tone code c
    task automatic model_cycle(int k, bit rs, bit en, bit [3:1] r);
        int hi = 0;
        for (int c = 1; c <= 3; c++) if (r[c]) hi = c;
        if (rs || !en) begin
            model_clear(k);
        end else if (hi > m_tone[k]) begin
            for (int c = 1; c <= 3; c++) if (r[c]) m_pend[k][c] = 1;
            model_start(k, hi);
        end else if (m_tone[k] != 0) begin
            for (int c = 1; c <= 3; c++) if (r[c]) m_pend[k][c] = 1;
            if (m_play[k] > 0) begin
                m_play[k]--;
                if (m_play[k] == 0) begin
                    if (gap_len[k] > 0) m_gap[k] = gap_len[k];
                    else                model_decide(k);
                end
            end else begin
                m_gap[k]--;
                if (m_gap[k] == 0) model_decide(k);
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        for (int k = 0; k < 2; k++) begin
            bit any_pend = m_pend[k][1] | m_pend[k][2] | m_pend[k][3];
            check($sformatf("sound%0d", k), 32'(snd[k]), 32'(m_tone[k]));
            check($sformatf("mute%0d", k),  32'(mut[k]), 32'(m_play[k] == 0));
            check($sformatf("busy%0d", k),  32'(bsy[k]), 32'((m_tone[k] != 0) || any_pend));
        end
    endtask

    // Drive one cycle of inputs, advance the model, check the registered outputs
    task automatic applyStimulus(bit rs, bit en, bit p, bit po, bit g);
        @(negedge clk);
        rst = rs; enable = en; ping_req = p; pong_req = po; goal_req = g;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_cycle(k, rs, en, {g, po, p});
        #1;
        checkOutput();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0);
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 1);
        check("reset_sound", 32'(snd[0]), 32'd0);
        check("reset_mute",  32'(mut[0]), 32'd1);
        check("reset_busy",  32'(bsy[0]), 32'd0);
        idle(2);

        // Single ping
        applyStimulus(0, 1, 1, 0, 0);
        check("ping_c1_sound", 32'(snd[0]), 32'd1);
        check("ping_c1_mute",  32'(mut[0]), 32'd0);
        idle(4);
        check("ping_c5_mute",  32'(mut[0]), 32'd1);
        check("ping_c5_sound", 32'(snd[0]), 32'd1);
        idle(2);
        check("ping_c7_sound", 32'(snd[0]), 32'd0);
        check("ping_c7_busy",  32'(bsy[0]), 32'd0);
        idle(3);

        // Ping and pong together: pong first, ping queued
        applyStimulus(0, 1, 1, 1, 0);
        check("pp_c1_sound", 32'(snd[0]), 32'd2);
        idle(8);
        check("pp_c9_sound", 32'(snd[0]), 32'd1);
        check("pp_c9_mute",  32'(mut[0]), 32'd0);
        idle(6);
        check("pp_c15_busy", 32'(bsy[0]), 32'd0);
        idle(2);

        // Goal preempts ping, ping not replayed
        applyStimulus(0, 1, 1, 0, 0);
        idle(1);
        applyStimulus(0, 1, 0, 0, 1);
        check("pg_c3_sound", 32'(snd[0]), 32'd3);
        idle(10);
        check("pg_c13_sound", 32'(snd[0]), 32'd0);
        check("pg_c13_busy",  32'(bsy[0]), 32'd0);
        idle(2);

        // Pong, ping queued, goal preempts and drops the queued ping
        applyStimulus(0, 1, 0, 1, 0);
        idle(2);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 1);
        check("ppg_c5_sound", 32'(snd[0]), 32'd3);
        idle(10);
        check("ppg_c15_busy", 32'(bsy[0]), 32'd0);
        idle(2);

        // Reset in the middle of a goal tone
        applyStimulus(0, 1, 0, 0, 1);
        idle(2);
        applyStimulus(1, 1, 0, 0, 0);
        check("rst_c4_sound", 32'(snd[0]), 32'd0);
        check("rst_c4_busy",  32'(bsy[0]), 32'd0);
        idle(1);
        applyStimulus(0, 1, 1, 0, 0);
        check("rst_c6_sound", 32'(snd[0]), 32'd1);
        idle(8);

        // Disabled: requests ignored
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        check("dis_mute", 32'(mut[0]), 32'd1);
        check("dis_busy", 32'(bsy[0]), 32'd0);
        applyStimulus(0, 1, 1, 0, 0);
        check("reen_sound", 32'(snd[0]), 32'd1);
        check("reen_mute",  32'(mut[0]), 32'd0);
        idle(8);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit rs = ($urandom_range(0, 199) == 0);
            bit en = ($urandom_range(0, 49) != 0);
            bit p  = ($urandom_range(0, 7) == 0);
            bit po = ($urandom_range(0, 9) == 0);
            bit g  = ($urandom_range(0, 19) == 0);
            applyStimulus(rs, en, p, po, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
